// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
package fifo_pkg;

   typedef enum logic {
      ARB_IDLE,
      ARB_GRANT
   } arb_state_t;

   localparam int unsigned ARB_NUM_REQ    = 4;
   localparam int unsigned ARB_DATA_WIDTH = 8;
   localparam int unsigned ARB_MAX_BURST  = 4;

   localparam int unsigned REQ_IDX_W   = $clog2(ARB_NUM_REQ);
   localparam int unsigned BURST_CNT_W = $clog2(ARB_MAX_BURST + 1);

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set bit of req scanning last+1, last+2, ... with wrap.
module rr_priority_picker #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic             found,
   output logic [IDX_W-1:0] next
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   int unsigned    pos;

   // Rotate so bit 0 is the index after 'last', priority-encode, then unrotate.
   always_comb begin
      dbl   = {req, req} >> (int'(last) + 1);
      rot   = dbl[N-1:0];
      found = |rot;
      pos   = 0;
      for (int unsigned i = N; i > 0; i--) begin
         if (rot[i-1]) pos = i - 1;
      end
      next = IDX_W'((int'(last) + 1 + int'(pos)) % N);
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one registered FIFO write port among producers.
module fifo_write_arbiter
   import fifo_pkg::*;
#(
   parameter int unsigned NUM_REQ    = ARB_NUM_REQ,
   parameter int unsigned DATA_WIDTH = ARB_DATA_WIDTH,
   parameter int unsigned MAX_BURST  = ARB_MAX_BURST
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          arb_en,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   input  logic                          fifo_almost_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   output logic                          grant_valid,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   arb_state_t            state_q, state_d;
   logic [IDX_W-1:0]      grant_id_q, grant_id_d;
   logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
   logic                  wr_en_q, wr_en_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

   logic                  ok;
   logic                  accept;
   logic                  owner_valid;
   logic [DATA_WIDTH-1:0] owner_data;
   logic                  pick_found;
   logic [IDX_W-1:0]      pick_idx;

   rr_priority_picker #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req   (req_valid),
      .last  (grant_id_q),
      .found (pick_found),
      .next  (pick_idx)
   );

   assign owner_valid  = req_valid[grant_id_q];
   assign owner_data   = req_data[int'(grant_id_q) * DATA_WIDTH +: DATA_WIDTH];
   assign fifo_wr_en   = wr_en_q;
   assign fifo_wr_data = wr_data_q;
   assign grant_valid  = (state_q == ARB_GRANT);
   assign grant_id     = grant_id_q;

   // State and write-port registers; reset discards any beat not yet presented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB_IDLE;
         grant_id_q  <= IDX_W'(NUM_REQ - 1);
         burst_cnt_q <= '0;
         wr_en_q     <= 1'b0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         grant_id_q  <= grant_id_d;
         burst_cnt_q <= burst_cnt_d;
         wr_en_q     <= wr_en_d;
         wr_data_q   <= wr_data_d;
      end
   end

   // Next state: grant in IDLE, release on valid drop or last beat of the burst.
   always_comb begin
      state_d     = state_q;
      grant_id_d  = grant_id_q;
      burst_cnt_d = burst_cnt_q;
      wr_en_d     = accept;
      wr_data_d   = accept ? owner_data : wr_data_q;
      case (state_q)
         ARB_IDLE: begin
            if (arb_en && pick_found) begin
               state_d     = ARB_GRANT;
               grant_id_d  = pick_idx;
               burst_cnt_d = '0;
            end
         end
         ARB_GRANT: begin
            if (!owner_valid) begin
               state_d = ARB_IDLE;
            end else if (accept) begin
               burst_cnt_d = burst_cnt_q + 1'b1;
               if (burst_cnt_q == CNT_W'(MAX_BURST - 1)) state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Outputs: ready only for the owner; the in-flight write counts against almost-full.
   always_comb begin
      ok        = !fifo_full && !(wr_en_q && fifo_almost_full);
      req_ready = '0;
      if (state_q == ARB_GRANT) req_ready[grant_id_q] = owner_valid && ok;
      accept    = |req_ready;
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic          clk;
   logic          rst_n;
   logic          arb_en;
   logic [N-1:0]  req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]  req_ready;
   logic          fifo_full;
   logic          fifo_almost_full;
   logic          fifo_wr_en;
   logic [DW-1:0] fifo_wr_data;
   logic          grant_valid;
   logic [1:0]    grant_id;

   fifo_write_arbiter #(
      .NUM_REQ    (N),
      .DATA_WIDTH (DW),
      .MAX_BURST  (MB)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .arb_en           (arb_en),
      .req_valid        (req_valid),
      .req_data         (req_data),
      .req_ready        (req_ready),
      .fifo_full        (fifo_full),
      .fifo_almost_full (fifo_almost_full),
      .fifo_wr_en       (fifo_wr_en),
      .fifo_wr_data     (fifo_wr_data),
      .grant_valid      (grant_valid),
      .grant_id         (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: who owns the port, how many beats taken, pending write
   bit          m_own;
   int          m_id;
   int          m_cnt;
   bit          m_wr_en;
   logic [DW-1:0] m_wr_data;

   logic [N-1:0] last_rdy;
   bit           prev_gv;
   int           grants_q[$];
   int           wr_count;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_own     = 0;
      m_id      = N - 1;
      m_cnt     = 0;
      m_wr_en   = 0;
      m_wr_data = '0;
   endtask

   function automatic logic [N-1:0] exp_ready();
      logic [N-1:0] r;
      bit ok;
      r  = '0;
      ok = !fifo_full && !(m_wr_en && fifo_almost_full);
      if (m_own && req_valid[m_id] && ok) r[m_id] = 1'b1;
      return r;
   endfunction

   task automatic model_update(input logic [N-1:0] er);
      bit acc;
      if (!rst_n) begin
         m_reset();
         return;
      end
      acc     = |er;
      m_wr_en = acc;
      if (acc) m_wr_data = req_data[m_id*DW +: DW];
      if (!m_own) begin
         if (arb_en && |req_valid) begin
            for (int k = 1; k <= N; k++) begin
               if (req_valid[(m_id + k) % N]) begin
                  m_id = (m_id + k) % N;
                  break;
               end
            end
            m_own = 1;
            m_cnt = 0;
         end
      end else if (!req_valid[m_id]) begin
         m_own = 0;
      end else if (acc) begin
         m_cnt++;
         if (m_cnt == MB) m_own = 0;
      end
   endtask

   // one clock: called just after a negedge with inputs already set
   task automatic cycle();
      logic [N-1:0] er;
      #1;
      er = exp_ready();
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("grant_valid", 32'(grant_valid), 32'(m_own));
      chk("grant_id", 32'(grant_id), m_id);
      chk("fifo_wr_en", 32'(fifo_wr_en), 32'(m_wr_en));
      chk("fifo_wr_data", 32'(fifo_wr_data), 32'(m_wr_data));
      if (grant_valid && !prev_gv) grants_q.push_back(int'(grant_id));
      prev_gv = grant_valid;
      if (fifo_wr_en) wr_count++;
      last_rdy = er;
      @(posedge clk);
      model_update(er);
      @(negedge clk);
   endtask

   // producers: hold valid/data while not accepted, otherwise re-roll
   task automatic drive(input logic [N-1:0] mask, input int pct);
      for (int i = 0; i < N; i++) begin
         if (!(req_valid[i] && !last_rdy[i])) begin
            req_valid[i] = mask[i] && ($urandom_range(99) < pct);
            req_data[i*DW +: DW] = 8'($urandom);
         end
      end
   endtask

   task automatic drain();
      req_valid = '0;
      repeat (3) cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_rot[5] = '{0, 1, 2, 3, 0};
      int acc;
      int hold_id;

      rst_n = 1'b1; arb_en = 1'b1; req_valid = '0; req_data = '0;
      fifo_full = 1'b0; fifo_almost_full = 1'b0; last_rdy = '0; prev_gv = 0;
      wr_count = 0;
      m_reset();
      #1 rst_n = 1'b0;
      req_valid = 4'b1111;
      req_data  = 32'h44332211;
      @(negedge clk);

      // reset held with all producers requesting
      repeat (2) cycle();
      chk("rst_grant_id", 32'(grant_id), 3);
      chk("rst_ready", 32'(req_ready), 0);
      rst_n = 1'b1;

      // rotation: everyone always valid, fifo empty
      grants_q.delete();
      for (int c = 0; c < 28; c++) begin
         drive(4'b1111, 100);
         cycle();
      end
      for (int i = 0; i < 5; i++)
         chk("rot_order", (grants_q.size() > i) ? grants_q[i] : -1, exp_rot[i]);

      // early release: producer 2 offers two beats then goes quiet
      drain();
      wr_count = 0;
      acc = 0;
      req_valid = 4'b0100;
      req_data[2*DW +: DW] = 8'hA5;
      for (int c = 0; c < 20 && acc < 2; c++) begin
         cycle();
         if (last_rdy[2]) begin
            acc++;
            req_data[2*DW +: DW] = 8'h5A;
            if (acc == 2) req_valid = '0;
         end
      end
      repeat (4) cycle();
      chk("early_writes", wr_count, 2);
      chk("early_grant_id", 32'(grant_id), 2);
      chk("early_gv", 32'(grant_valid), 0);

      // almost-full: accept only every other cycle
      fifo_almost_full = 1'b1;
      for (int c = 0; c < 20; c++) begin
         drive(4'b1111, 100);
         #1;
         if (fifo_wr_en) chk("af_alternate", 32'(req_ready), 0);
         #(-0);
         cycle();
      end
      // full: grant kept, nothing accepted
      fifo_full = 1'b1;
      hold_id = -1;
      for (int c = 0; c < 6; c++) begin
         drive(4'b1111, 100);
         cycle();
      end
      hold_id = int'(grant_id);
      cycle();
      chk("full_ready", 32'(req_ready), 0);
      chk("full_gv", 32'(grant_valid), 1);
      chk("full_hold_id", 32'(grant_id), hold_id);
      fifo_full = 1'b0;
      fifo_almost_full = 1'b0;

      // arb_en dropped after beat 2: burst completes, then no new grant
      drain();
      acc = 0;
      for (int c = 0; c < 20; c++) begin
         drive(4'b1111, 100);
         cycle();
         if (|last_rdy) acc++;
         if (acc == 2) arb_en = 1'b0;
      end
      chk("arb_off_beats", acc, 4);
      chk("arb_off_gv", 32'(grant_valid), 0);
      arb_en = 1'b1;

      // async reset in the middle of a burst
      acc = 0;
      for (int c = 0; c < 20 && !(m_own && m_wr_en); c++) begin
         drive(4'b1111, 100);
         cycle();
      end
      chk("midburst_reached", 32'(m_own && m_wr_en), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_wr_en", 32'(fifo_wr_en), 0);
      chk("async_gv", 32'(grant_valid), 0);
      chk("async_ready", 32'(req_ready), 0);
      m_reset();
      prev_gv  = 0;
      last_rdy = '0;
      @(negedge clk);
      cycle();
      rst_n = 1'b1;
      grants_q.delete();
      for (int c = 0; c < 6; c++) begin
         drive(4'b1111, 100);
         cycle();
      end
      chk("post_rst_grant", (grants_q.size() > 0) ? grants_q[0] : -1, 0);

      // random mix of everything
      for (int c = 0; c < 400; c++) begin
         arb_en           = ($urandom_range(99) < 90);
         fifo_almost_full = ($urandom_range(99) < 30);
         fifo_full        = ($urandom_range(99) < 15);
         drive(4'($urandom), 60);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
